// File: rtl/layer_vector_buffer_if.sv
// Handshake bundle for layer_vector_buffer: upstream word stream in, downstream vector stream out.
// slave is the buffer's view; master is the surrounding layers' view.
interface layer_vector_buffer_if #(
    parameter int M    = 16,
    parameter int T    = 20,
    parameter int logM = $clog2(M + 1)
);
    logic                   s_valid;
    logic                   s_ready;
    logic signed [T-1:0]    data_in;
    logic                   m_valid;
    logic                   m_ready;
    logic signed [T-1:0]    data_out;
    logic                   m_last;
    logic [logM-1:0]        argmax;

    modport slave (
        input  s_valid, data_in, m_ready,
        output s_ready, m_valid, data_out, m_last, argmax
    );

    modport master (
        output s_valid, data_in, m_ready,
        input  s_ready, m_valid, data_out, m_last, argmax
    );
endinterface

// File: rtl/layer_vector_buffer.sv
// Single-vector buffer between FC layers: fills M words, then replays them in order downstream.
// Optional argmax tracker compiled in with LAYER_VECTOR_BUFFER_ARGMAX_EN.
module layer_vector_buffer #(
    parameter int M    = 16,
    parameter int T    = 20,
    parameter int logM = $clog2(M + 1)
) (
    input logic                  clk,
    input logic                  reset,
    layer_vector_buffer_if.slave bus
);
    localparam int AW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {FILL, PREFETCH, DRAIN} state_t;

    state_t              state;
    logic signed [T-1:0] mem [M];
    logic [logM-1:0]     wr_cnt;
    logic [logM-1:0]     rd_addr;
    logic                s_ready_q;
    logic signed [T-1:0] rd_p0;
    logic                vld_p0;
    logic signed [T-1:0] out_p1;
    logic                vld_p1;
    logic                last_p1;

    logic accept;
    logic wr_last;
    logic advance;
    logic rd_more;
    logic rd_en;

    assign accept  = s_ready_q && bus.s_valid;
    assign wr_last = (wr_cnt == logM'(M - 1));
    assign advance = !vld_p1 || bus.m_ready;
    assign rd_more = (rd_addr != logM'(M));
    // rd_p0 only refills when its word moves into the output register, so a stall keeps it
    assign rd_en   = (state == PREFETCH) ||
                     ((state == DRAIN) && advance && vld_p0 && rd_more);

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_cnt[AW-1:0]] <= bus.data_in;
        end
        if (rd_en) begin
            rd_p0 <= mem[rd_addr[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FILL;
            s_ready_q <= 1'b0;
            wr_cnt    <= '0;
            rd_addr   <= '0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            out_p1    <= '0;
        end else begin
            case (state)
                FILL: begin
                    s_ready_q <= 1'b1;
                    if (accept) begin
                        if (wr_last) begin
                            wr_cnt    <= '0;
                            s_ready_q <= 1'b0;
                            state     <= PREFETCH;
                        end else begin
                            wr_cnt <= wr_cnt + logM'(1);
                        end
                    end
                end
                PREFETCH: begin
                    rd_addr <= logM'(1);
                    vld_p0  <= 1'b1;
                    state   <= DRAIN;
                end
                DRAIN: begin
                    // p0 -> p1 stage boundary: move the prefetched word into the output register
                    if (advance) begin
                        if (vld_p0) begin
                            out_p1  <= rd_p0;
                            vld_p1  <= 1'b1;
                            last_p1 <= !rd_more;
                            if (rd_more) begin
                                rd_addr <= rd_addr + logM'(1);
                            end else begin
                                vld_p0 <= 1'b0;
                            end
                        end else begin
                            vld_p1    <= 1'b0;
                            last_p1   <= 1'b0;
                            rd_addr   <= '0;
                            s_ready_q <= 1'b1;
                            state     <= FILL;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.s_ready  = s_ready_q;
    assign bus.m_valid  = vld_p1;
    assign bus.m_last   = last_p1;
    assign bus.data_out = out_p1;

`ifdef LAYER_VECTOR_BUFFER_ARGMAX_EN
    logic signed [T-1:0] max_val;
    logic [logM-1:0]     max_idx;
    logic [logM-1:0]     argmax_q;
    logic                take_max;
    logic [logM-1:0]     idx_nxt;

    // strict greater-than keeps the lower index on ties
    assign take_max = (wr_cnt == '0) || (bus.data_in > max_val);
    assign idx_nxt  = take_max ? wr_cnt : max_idx;

    always_ff @(posedge clk) begin
        if (accept && take_max) begin
            max_val <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_idx  <= '0;
            argmax_q <= '0;
        end else if (accept) begin
            max_idx <= idx_nxt;
            if (wr_last) begin
                argmax_q <= idx_nxt;
            end
        end
    end

    assign bus.argmax = argmax_q;
`else
    assign bus.argmax = '0;
`endif
endmodule
